fp_exe_arb: RTL and testbench

- Two-requester arbiter and sequencer in front of the single shared fp_exe unit.
- Accepts FP operations from port 0 and port 1 with valid/ready handshakes and grants them round-robin.
- Holds operands stable while fp_exe runs: one cycle for simple ops, many cycles for fma/fdiv.
- Returns the result and flags to the owning requester, and aborts via watchdog if fp_exe never completes.

---
 rtl/fp_exe_arb.sv | 152 +++++++++++++++
 tb/tb_fp_exe_arb.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_exe_arb.sv
// fp_exe_arb: two-port round-robin arbiter and sequencer in front of a single fp_exe unit.
// Operands are registered on grant and held until the next grant; results return to the
// owning port as a one-cycle pulse, or as an error pulse if the watchdog expires.
module fp_exe_arb #(
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned CNTW    = 10
) (
  input  logic        clock,
  input  logic        reset,
  // Port 0 request
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [31:0] req0_data3,
  input  logic [15:0] req0_op,
  input  logic [1:0]  req0_fmt,
  input  logic [2:0]  req0_rm,
  // Port 1 request
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [31:0] req1_data3,
  input  logic [15:0] req1_op,
  input  logic [1:0]  req1_fmt,
  input  logic [2:0]  req1_rm,
  // Responses
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic [4:0]  rsp0_flags,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic [4:0]  rsp1_flags,
  output logic        rsp1_err,
  // fp_exe interface
  output logic        exe_enable,
  output logic [31:0] exe_data1,
  output logic [31:0] exe_data2,
  output logic [31:0] exe_data3,
  output logic [15:0] exe_op,
  output logic [1:0]  exe_fmt,
  output logic [2:0]  exe_rm,
  input  logic [31:0] exe_result,
  input  logic [4:0]  exe_flags,
  input  logic        exe_ready,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              prio_q, owner_q;
  logic [CNTW-1:0]   count_q;
  logic [31:0]       data1_q, data2_q, data3_q, result_q;
  logic [15:0]       op_q;
  logic [1:0]        fmt_q;
  logic [2:0]        rm_q;
  logic [4:0]        flags_q;
  logic              err_q;
  logic              grant, grant_id, timeout;

  // Arbitration: only in IDLE and never while reset is asserted; ties go to prio_q.
  always_comb begin
    grant    = (state_q == StIdle) && !reset && (req0_valid || req1_valid);
    grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
    timeout  = (state_q == StWait) && (count_q == CNTW'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; exe_ready is only looked at in ISSUE and WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      StIssue: state_d = exe_ready ? StDone : StWait;
      StWait:  if (exe_ready || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand capture on grant, watchdog count, result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      count_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      data3_q  <= '0;
      op_q     <= '0;
      fmt_q    <= '0;
      rm_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (grant) begin
        prio_q  <= ~grant_id;
        owner_q <= grant_id;
        data1_q <= grant_id ? req1_data1 : req0_data1;
        data2_q <= grant_id ? req1_data2 : req0_data2;
        data3_q <= grant_id ? req1_data3 : req0_data3;
        op_q    <= grant_id ? req1_op    : req0_op;
        fmt_q   <= grant_id ? req1_fmt   : req0_fmt;
        rm_q    <= grant_id ? req1_rm    : req0_rm;
      end
      if (state_q == StIssue)     count_q <= '0;
      else if (state_q == StWait) count_q <= count_q + CNTW'(1);
      // A real completion beats the watchdog in the same cycle.
      if ((state_q == StIssue || state_q == StWait) && exe_ready) begin
        result_q <= exe_result;
        flags_q  <= exe_flags;
        err_q    <= 1'b0;
      end else if (timeout) begin
        result_q <= '0;
        flags_q  <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  // Outputs: handshakes, held exe operands, and owner-gated response buses.
  always_comb begin
    req0_ready  = grant && !grant_id;
    req1_ready  = grant && grant_id;
    exe_enable  = (state_q == StIssue);
    exe_data1   = data1_q;
    exe_data2   = data2_q;
    exe_data3   = data3_q;
    exe_op      = op_q;
    exe_fmt     = fmt_q;
    exe_rm      = rm_q;
    busy        = (state_q != StIdle);
    rsp0_valid  = (state_q == StDone) && !owner_q;
    rsp1_valid  = (state_q == StDone) && owner_q;
    rsp0_result = rsp0_valid ? result_q : '0;
    rsp0_flags  = rsp0_valid ? flags_q  : '0;
    rsp0_err    = rsp0_valid ? err_q    : 1'b0;
    rsp1_result = rsp1_valid ? result_q : '0;
    rsp1_flags  = rsp1_valid ? flags_q  : '0;
    rsp1_err    = rsp1_valid ? err_q    : 1'b0;
  end

endmodule

// File: tb/tb_fp_exe_arb.sv
// Directed bench for fp_exe_arb: one default instance and one with a short watchdog.
module tb_fp_exe_arb;

  localparam logic [15:0] OpFadd   = 16'h0001;
  localparam logic [15:0] OpFmul   = 16'h0004;
  localparam logic [15:0] OpFdiv   = 16'h0008;
  localparam logic [15:0] OpFsgnj  = 16'h0040;
  localparam logic [15:0] OpFclass = 16'h0200;
  localparam logic [15:0] OpFmvF2i = 16'h0800;

  logic        clock, reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data1, req0_data2, req0_data3, req1_data1, req1_data2, req1_data3;
  logic [15:0] req0_op, req1_op;
  logic [1:0]  req0_fmt, req1_fmt;
  logic [2:0]  req0_rm, req1_rm;
  logic [31:0] exe_result;
  logic [4:0]  exe_flags;
  logic        exe_ready;

  // Main instance outputs
  logic        req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result, exe_data1, exe_data2, exe_data3;
  logic [4:0]  rsp0_flags, rsp1_flags;
  logic        exe_enable, busy;
  logic [15:0] exe_op;
  logic [1:0]  exe_fmt;
  logic [2:0]  exe_rm;

  // Short-watchdog instance outputs
  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp0_err, b_rsp1_valid, b_rsp1_err;
  logic [31:0] b_rsp0_result, b_rsp1_result, b_exe_data1, b_exe_data2, b_exe_data3;
  logic [4:0]  b_rsp0_flags, b_rsp1_flags;
  logic        b_exe_enable, b_busy;
  logic [15:0] b_exe_op;
  logic [1:0]  b_exe_fmt;
  logic [2:0]  b_exe_rm;

  // Exe model controls
  logic        echo, man_ready;
  logic [31:0] man_result;
  logic [4:0]  man_flags;

  int errors = 0;
  int checks = 0;

  fp_exe_arb u_dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_data3(req0_data3), .req0_op(req0_op),
    .req0_fmt(req0_fmt), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_data3(req1_data3), .req1_op(req1_op),
    .req1_fmt(req1_fmt), .req1_rm(req1_rm),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .rsp1_err(rsp1_err),
    .exe_enable(exe_enable), .exe_data1(exe_data1), .exe_data2(exe_data2),
    .exe_data3(exe_data3), .exe_op(exe_op), .exe_fmt(exe_fmt), .exe_rm(exe_rm),
    .exe_result(exe_result), .exe_flags(exe_flags), .exe_ready(exe_ready), .busy(busy)
  );

  fp_exe_arb #(.TIMEOUT(4), .CNTW(10)) u_dut4 (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_data3(req0_data3), .req0_op(req0_op),
    .req0_fmt(req0_fmt), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_data3(req1_data3), .req1_op(req1_op),
    .req1_fmt(req1_fmt), .req1_rm(req1_rm),
    .rsp0_valid(b_rsp0_valid), .rsp0_result(b_rsp0_result), .rsp0_flags(b_rsp0_flags),
    .rsp0_err(b_rsp0_err),
    .rsp1_valid(b_rsp1_valid), .rsp1_result(b_rsp1_result), .rsp1_flags(b_rsp1_flags),
    .rsp1_err(b_rsp1_err),
    .exe_enable(b_exe_enable), .exe_data1(b_exe_data1), .exe_data2(b_exe_data2),
    .exe_data3(b_exe_data3), .exe_op(b_exe_op), .exe_fmt(b_exe_fmt), .exe_rm(b_exe_rm),
    .exe_result(exe_result), .exe_flags(exe_flags), .exe_ready(exe_ready), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Exe model: echo data1 with ready=enable, or bench-driven values.
  always_comb begin
    if (echo) begin
      exe_ready  = exe_enable;
      exe_result = exe_data1;
      exe_flags  = '0;
    end else begin
      exe_ready  = man_ready;
      exe_result = man_result;
      exe_flags  = man_flags;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_reqs();
    req0_valid = 0; req0_data1 = 0; req0_data2 = 0; req0_data3 = 0;
    req0_op = 0; req0_fmt = 0; req0_rm = 0;
    req1_valid = 0; req1_data1 = 0; req1_data2 = 0; req1_data3 = 0;
    req1_op = 0; req1_fmt = 0; req1_rm = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, exe_enable, busy,
         exe_data1, exe_data2, exe_data3, exe_op, exe_fmt, exe_rm} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready0=%b en=%b busy=%b d1=%h, want all 0",
               req0_ready, exe_enable, busy, exe_data1);
    end
    next_cycle();
    reset = 1'b0;
    req0_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({rsp0_result, rsp0_flags, rsp0_err, rsp1_result, rsp1_flags, rsp1_err,
         busy, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b b_busy=%b rsp0=%h, want 0", busy, b_busy,
               rsp0_result);
    end
  endtask

  task automatic test_simple_op();
    do_reset();
    echo = 1'b1;
    req0_valid = 1; req0_op = OpFmvF2i; req0_data1 = 32'h12345678;
    req0_data2 = 32'h0; req0_data3 = 32'h0; req0_fmt = 2'd0; req0_rm = 3'd0;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready, exe_enable} !== 3'b100) begin
      errors++;
      $display("FAIL t1_handshake: got rdy0,rdy1,en=%b want 100",
               {req0_ready, req1_ready, exe_enable});
    end
    next_cycle();
    req0_valid = 0;
    @(negedge clock);
    checks++;
    if ({exe_enable, busy, rsp0_valid, exe_data1, exe_op} !== {3'b110, 32'h12345678, OpFmvF2i})
    begin
      errors++;
      $display("FAIL t1_issue: got en=%b busy=%b d1=%h op=%h want en=1 busy=1 d1=12345678",
               exe_enable, busy, exe_data1, exe_op);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if ({rsp0_valid, rsp0_result, rsp0_flags, rsp0_err, rsp1_valid} !==
        {1'b1, 32'h12345678, 5'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL t1_rsp: got v=%b res=%h fl=%h err=%b v1=%b want 1 12345678 0 0 0",
               rsp0_valid, rsp0_result, rsp0_flags, rsp0_err, rsp1_valid);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if ({rsp0_valid, rsp0_result, busy, exe_data1} !== {1'b0, 32'h0, 1'b0, 32'h12345678}) begin
      errors++;
      $display("FAIL t1_after: got v=%b res=%h busy=%b d1=%h want 0 0 0 12345678",
               rsp0_valid, rsp0_result, busy, exe_data1);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    echo = 1'b1;
    req0_valid = 1; req0_op = OpFsgnj;  req0_data1 = 32'hC0490FDB;
    req1_valid = 1; req1_op = OpFclass; req1_data1 = 32'h7FC00000;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL t2_first_grant: got %b want 10", {req0_ready, req1_ready});
    end
    next_cycle();
    req0_valid = 0;
    @(negedge clock);
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL t2_no_grant_issue: got %b want 0", req1_ready);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if ({rsp0_valid, rsp0_result, req1_ready} !== {1'b1, 32'hC0490FDB, 1'b0}) begin
      errors++;
      $display("FAIL t2_rsp0: got v=%b res=%h rdy1=%b want 1 c0490fdb 0",
               rsp0_valid, rsp0_result, req1_ready);
    end
    next_cycle();
    req0_valid = 1; req0_data1 = 32'h3F000000;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL t2_prio1_grant: got %b want 01", {req0_ready, req1_ready});
    end
    next_cycle();
    req1_valid = 0;
    next_cycle();
    @(negedge clock);
    checks++;
    if ({rsp1_valid, rsp1_result, rsp0_valid, rsp0_result} !==
        {1'b1, 32'h7FC00000, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL t2_rsp1: got v1=%b res1=%h v0=%b res0=%h want 1 7fc00000 0 0",
               rsp1_valid, rsp1_result, rsp0_valid, rsp0_result);
    end
    next_cycle();
    req1_valid = 1;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL t2_prio0_grant: got %b want 10", {req0_ready, req1_ready});
    end
    next_cycle();
    clear_reqs();
    next_cycle();
    @(negedge clock);
    checks++;
    if ({rsp0_valid, rsp0_result} !== {1'b1, 32'h3F000000}) begin
      errors++;
      $display("FAIL t2_rsp0_second: got v=%b res=%h want 1 3f000000", rsp0_valid, rsp0_result);
    end
    next_cycle();
  endtask

  task automatic test_multi_cycle();
    int en_cnt;
    do_reset();
    echo = 1'b0; man_ready = 0; man_result = 32'hFFFFFFFF; man_flags = 5'h1F;
    req1_valid = 1; req1_op = OpFadd; req1_data1 = 32'h3F800000; req1_data2 = 32'h40000000;
    req1_data3 = 32'h11111111; req1_fmt = 2'd1; req1_rm = 3'd3;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL t3_grant: got %b want 01", {req0_ready, req1_ready});
    end
    next_cycle();
    clear_reqs();
    en_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) begin
        man_ready = 1; man_result = 32'h40400000; man_flags = 5'h01;
      end
      @(negedge clock);
      if (exe_enable === 1'b1) en_cnt++;
      checks++;
      if ({exe_data1, exe_data2, exe_data3, exe_op, exe_fmt, exe_rm, rsp1_valid, busy} !==
          {32'h3F800000, 32'h40000000, 32'h11111111, OpFadd, 2'd1, 3'd3, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL t3_hold_%0d: got d1=%h d2=%h d3=%h op=%h v1=%b busy=%b", i,
                 exe_data1, exe_data2, exe_data3, exe_op, rsp1_valid, busy);
      end
      next_cycle();
    end
    man_ready = 0;
    checks++;
    if (en_cnt !== 1) begin
      errors++;
      $display("FAIL t3_enable_cycles: got %0d want 1", en_cnt);
    end
    @(negedge clock);
    checks++;
    if ({rsp1_valid, rsp1_result, rsp1_flags, rsp1_err, rsp0_valid} !==
        {1'b1, 32'h40400000, 5'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL t3_rsp1: got v=%b res=%h fl=%h err=%b v0=%b want 1 40400000 01 0 0",
               rsp1_valid, rsp1_result, rsp1_flags, rsp1_err, rsp0_valid);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    echo = 1'b0; man_ready = 0; man_result = 32'hDEADBEEF; man_flags = 5'h1F;
    req0_valid = 1; req0_op = OpFdiv; req0_data1 = 32'h40A00000; req0_data2 = 32'h0;
    @(negedge clock);
    checks++;
    if (b_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL t4_grant: got %b want 1", b_req0_ready);
    end
    next_cycle();
    clear_reqs();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      checks++;
      if ({b_rsp0_valid, b_busy} !== 2'b01) begin
        errors++;
        $display("FAIL t4_wait_%0d: got v=%b busy=%b want 0 1", i, b_rsp0_valid, b_busy);
      end
      next_cycle();
    end
    @(negedge clock);
    checks++;
    if ({b_rsp0_valid, b_rsp0_result, b_rsp0_flags, b_rsp0_err} !==
        {1'b1, 32'h0, 5'h0, 1'b1}) begin
      errors++;
      $display("FAIL t4_abort: got v=%b res=%h fl=%h err=%b want 1 0 0 1",
               b_rsp0_valid, b_rsp0_result, b_rsp0_flags, b_rsp0_err);
    end
    next_cycle();
    req1_valid = 1; req1_op = OpFadd; req1_data1 = 32'h3F800000;
    @(negedge clock);
    checks++;
    if ({b_busy, b_req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL t4_reaccept: got busy=%b rdy1=%b want 0 1", b_busy, b_req1_ready);
    end
    next_cycle();
    clear_reqs();
    @(negedge clock);
    checks++;
    if ({b_exe_enable, b_exe_data1} !== {1'b1, 32'h3F800000}) begin
      errors++;
      $display("FAIL t4_reissue: got en=%b d1=%h want 1 3f800000", b_exe_enable, b_exe_data1);
    end
    next_cycle();
  endtask

  task automatic test_ready_vs_timeout();
    do_reset();
    echo = 1'b0; man_ready = 0; man_result = 32'h0; man_flags = 5'h0;
    req0_valid = 1; req0_op = OpFdiv; req0_data1 = 32'h3F800000;
    @(negedge clock);
    checks++;
    if (b_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL t5_grant: got %b want 1", b_req0_ready);
    end
    next_cycle();
    clear_reqs();
    for (int i = 1; i <= 4; i++) next_cycle();
    man_ready = 1; man_result = 32'h3EA00000; man_flags = 5'h02;
    @(negedge clock);
    checks++;
    if (b_rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_no_early_rsp: got %b want 0", b_rsp0_valid);
    end
    next_cycle();
    man_ready = 0;
    @(negedge clock);
    checks++;
    if ({b_rsp0_valid, b_rsp0_result, b_rsp0_flags, b_rsp0_err} !==
        {1'b1, 32'h3EA00000, 5'h02, 1'b0}) begin
      errors++;
      $display("FAIL t5_ready_wins: got v=%b res=%h fl=%h err=%b want 1 3ea00000 02 0",
               b_rsp0_valid, b_rsp0_result, b_rsp0_flags, b_rsp0_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    echo = 1'b0; man_ready = 0; man_result = 32'h0; man_flags = 5'h0;
    req0_valid = 1; req0_op = OpFmul; req0_data1 = 32'h40490FDB; req0_data2 = 32'h40000000;
    req0_fmt = 2'd1; req0_rm = 3'd2;
    @(negedge clock);
    next_cycle();
    clear_reqs();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t6_busy_before_edge: got %b want 1", busy);
    end
    next_cycle();
    reset = 1'b0;
    man_ready = 1; man_result = 32'h55555555; man_flags = 5'h04;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp0_flags, rsp0_err,
         exe_enable, busy, exe_data1, exe_data2, exe_op, exe_fmt, exe_rm} !== '0) begin
      errors++;
      $display("FAIL t6_all_zero: got v0=%b en=%b busy=%b d1=%h op=%h want all 0",
               rsp0_valid, exe_enable, busy, exe_data1, exe_op);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clock);
      checks++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL t6_no_rsp_%0d: got v0=%b v1=%b busy=%b want 0 0 0", i, rsp0_valid,
                 rsp1_valid, busy);
      end
    end
    next_cycle();
    man_ready = 0;
    req0_valid = 1; req1_valid = 1;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL t6_prio_reset: got %b want 10", {req0_ready, req1_ready});
    end
    next_cycle();
    clear_reqs();
  endtask

  initial begin
    echo = 1'b0; man_ready = 1'b0; man_result = '0; man_flags = '0;
    reset = 1'b1;
    clear_reqs();
    test_reset();
    test_simple_op();
    test_round_robin();
    test_multi_cycle();
    test_timeout();
    test_ready_vs_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
